// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: 8b/10b transition-minimising encode with DC balance, two pipeline stages.
// Optional macro TMDS_VIDEO_GUARD_EN adds a 2-slot delay line and inserts the video guard band.
module tmds_channel_encoder #(
    parameter int CHANNEL = 0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic       i_de,
    output logic [9:0] o_tmds,
    output logic [4:0] o_dbg_cnt
);

    localparam logic [9:0] CTRL_SYM_00 = 10'h354;
    localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
    localparam logic [9:0] CTRL_SYM_10 = 10'h154;
    localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

    if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
        $error("tmds_channel_encoder: CHANNEL must be 0..2");
    end

    logic [3:0] w_n1_data;
    logic       w_use_xnor;
    logic [8:0] w_qm;

    always_comb begin
        w_n1_data = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1_data = w_n1_data + {3'd0, i_data[i]};
        end
        w_use_xnor = (w_n1_data > 4'd4) || ((w_n1_data == 4'd4) && !i_data[0]);
        w_qm    = 9'd0;
        w_qm[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
        end
        w_qm[8] = ~w_use_xnor;
    end

    logic       r_de1;
    logic [1:0] r_ctrl1;
    logic [8:0] r_qm1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_de1   <= 1'b0;
            r_ctrl1 <= 2'b00;
            r_qm1   <= 9'd0;
        end else begin
            r_de1   <= i_de;
            r_ctrl1 <= i_ctrl;
            r_qm1   <= w_qm;
        end
    end

    // Disparity values are 5-bit two's complement; the sign bit decides cnt/diff polarity.
    logic [4:0] r_cnt;
    logic [9:0] r_tmds2;
    logic [3:0] w_n1_qm;
    logic [4:0] w_diff;
    logic [4:0] w_cnt_next;
    logic [9:0] w_sym;
    logic       w_qm8;
    logic [7:0] w_q;

    always_comb begin
        w_q     = r_qm1[7:0];
        w_qm8   = r_qm1[8];
        w_n1_qm = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1_qm = w_n1_qm + {3'd0, w_q[i]};
        end
        w_diff     = {w_n1_qm, 1'b0} - 5'd8;
        w_sym      = CTRL_SYM_00;
        w_cnt_next = 5'd0;
        if (!r_de1) begin
            case (r_ctrl1)
                2'b00:   w_sym = CTRL_SYM_00;
                2'b01:   w_sym = CTRL_SYM_01;
                2'b10:   w_sym = CTRL_SYM_10;
                default: w_sym = CTRL_SYM_11;
            endcase
            w_cnt_next = 5'd0;
        end else if ((r_cnt == 5'd0) || (w_diff == 5'd0)) begin
            w_sym      = {~w_qm8, w_qm8, w_qm8 ? w_q : ~w_q};
            w_cnt_next = w_qm8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (r_cnt[4] == w_diff[4]) begin
            // Both non-zero here, so equal sign bits mean the running bias would grow.
            w_sym      = {1'b1, w_qm8, ~w_q};
            w_cnt_next = r_cnt + {3'd0, w_qm8, 1'b0} - w_diff;
        end else begin
            w_sym      = {1'b0, w_qm8, w_q};
            w_cnt_next = r_cnt + w_diff - {3'd0, ~w_qm8, 1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tmds2 <= CTRL_SYM_00;
            r_cnt   <= 5'd0;
        end else begin
            r_tmds2 <= w_sym;
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_dbg_cnt = r_cnt;

`ifdef TMDS_VIDEO_GUARD_EN
    localparam logic [9:0] GUARD_SYM = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

    logic       r_de2;
    logic [9:0] r_dl1_sym;
    logic       r_dl1_de;
    logic [9:0] r_dl2_sym;
    logic       w_rise;

    // Pixel 0 is entering stage 2 this edge; the two older slots are still held back.
    assign w_rise = r_de1 & ~r_de2;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_de2     <= 1'b0;
            r_dl1_sym <= CTRL_SYM_00;
            r_dl1_de  <= 1'b0;
            r_dl2_sym <= CTRL_SYM_00;
        end else begin
            r_de2     <= r_de1;
            r_dl1_sym <= w_rise ? GUARD_SYM : r_tmds2;
            r_dl1_de  <= r_de2;
            r_dl2_sym <= (w_rise && !r_dl1_de) ? GUARD_SYM : r_dl1_sym;
        end
    end

    assign o_tmds = r_dl2_sym;
`else
    assign o_tmds = r_tmds2;
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: three lanes share stimulus, a spec-level model fills
// expected queues, and a monitor pops and compares every output slot and disparity value.
`timescale 1ns/1ps
module tb_tmds_channel_encoder;

    localparam int HALF = 5;
`ifdef TMDS_VIDEO_GUARD_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic [9:0] tmds0, tmds1, tmds2;
    logic [4:0] cnt0, cnt1, cnt2;

    tmds_channel_encoder #(.CHANNEL(0)) u_ch0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_data(data), .i_ctrl(ctrl), .i_de(de),
        .o_tmds(tmds0), .o_dbg_cnt(cnt0));
    tmds_channel_encoder #(.CHANNEL(1)) u_ch1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_data(data), .i_ctrl(ctrl), .i_de(de),
        .o_tmds(tmds1), .o_dbg_cnt(cnt1));
    tmds_channel_encoder #(.CHANNEL(2)) u_ch2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_data(data), .i_ctrl(ctrl), .i_de(de),
        .o_tmds(tmds2), .o_dbg_cnt(cnt2));

    // ---------------- clock / reset / edge count ----------------
    always #HALF clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [9:0]  sym;
        logic        de;
        logic        guard;
        int unsigned due;
    } sym_exp_t;

    typedef struct {
        logic [4:0]  cnt;
        int unsigned due;
    } cnt_exp_t;

    sym_exp_t exp_q[$];
    cnt_exp_t cnt_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    logic     in_reset;
    int       m_cnt;
    logic     m_prev_de;
    sym_exp_t mon_e;
    cnt_exp_t mon_c;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%03h, expected 0x%03h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [9:0] tmds_of(input int ch);
        case (ch)
            0:       return tmds0;
            1:       return tmds1;
            default: return tmds2;
        endcase
    endfunction

    function automatic logic [4:0] cnt_of(input int ch);
        case (ch)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    function automatic logic [9:0] guard_sym(input int ch);
        return (ch == 1) ? 10'h133 : 10'h2CC;
    endfunction

    // ---------------- reference model + driver ----------------
    task automatic apply(input logic a_de, input logic [7:0] a_data, input logic [1:0] a_ctrl);
        sym_exp_t    e;
        sym_exp_t    tmp;
        cnt_exp_t    c;
        int unsigned s;
        int          n1d, n1, n0;
        logic        xn;
        logic [8:0]  qm;
        logic [9:0]  sym;
        de   = a_de;
        data = a_data;
        ctrl = a_ctrl;
        s    = edge_cnt + 1;
        if (!a_de) begin
            case (a_ctrl)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            m_cnt = 0;
        end else begin
            n1d   = $countones(a_data);
            xn    = (n1d > 4) || (n1d == 4 && a_data[0] == 1'b0);
            qm    = 9'd0;
            qm[0] = a_data[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ a_data[i]) : (qm[i-1] ^ a_data[i]);
            qm[8] = !xn;
            n1    = $countones(qm[7:0]);
            n0    = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
            end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
                sym   = {1'b1, qm[8], ~qm[7:0]};
                m_cnt = m_cnt + 2 * int'(qm[8]) + (n0 - n1);
            end else begin
                sym   = {1'b0, qm[8], qm[7:0]};
                m_cnt = m_cnt - 2 * int'(!qm[8]) + (n1 - n0);
            end
        end
`ifdef TMDS_VIDEO_GUARD_EN
        if (a_de && !m_prev_de) begin
            for (int k = 1; k <= 2; k++) begin
                if (exp_q.size() >= k && !exp_q[exp_q.size() - k].de) begin
                    tmp = exp_q[exp_q.size() - k];
                    tmp.guard = 1'b1;
                    exp_q[exp_q.size() - k] = tmp;
                end
            end
        end
`endif
        e.sym   = sym;
        e.de    = a_de;
        e.guard = 1'b0;
        e.due   = s + LAT - 1;
        exp_q.push_back(e);
        c.cnt = m_cnt[4:0];
        c.due = s + 1;
        cnt_q.push_back(c);
        m_prev_de = a_de;
    endtask

    task automatic drive(input logic a_de, input logic [7:0] a_data, input logic [1:0] a_ctrl);
        @(negedge clk);
        apply(a_de, a_data, a_ctrl);
    endtask

    task automatic check_reset_values(input string name);
        for (int ch = 0; ch < 3; ch++) begin
            check($sformatf("%s_tmds_ch%0d", name, ch), tmds_of(ch), 10'h354);
            check($sformatf("%s_cnt_ch%0d", name, ch), {5'd0, cnt_of(ch)}, 10'd0);
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        in_reset = 1'b1;
        de       = 1'b0;
        ctrl     = 2'b00;
        exp_q.delete();
        cnt_q.delete();
        #1;
        check_reset_values("reset_async");
        @(posedge clk);
        #2;
        check_reset_values("reset_hold");
    endtask

    task automatic release_reset();
        sym_exp_t e;
        cnt_exp_t c;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < LAT - 1; k++) begin
            e.sym   = 10'h354;
            e.de    = 1'b0;
            e.guard = 1'b0;
            e.due   = edge_cnt + 1 + k;
            exp_q.push_back(e);
        end
        c.cnt = 5'd0;
        c.due = edge_cnt + 1;
        cnt_q.push_back(c);
        m_cnt     = 0;
        m_prev_de = 1'b0;
        in_reset  = 1'b0;
        apply(1'b0, 8'($urandom_range(0, 255)), 2'b00);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #2;
        if (!in_reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                mon_e = exp_q.pop_front();
                for (int ch = 0; ch < 3; ch++) begin
                    check($sformatf("tmds_ch%0d", ch), tmds_of(ch),
                          mon_e.guard ? guard_sym(ch) : mon_e.sym);
                end
            end
            if (cnt_q.size() > 0 && cnt_q[0].due == edge_cnt) begin
                mon_c = cnt_q.pop_front();
                for (int ch = 0; ch < 3; ch++) begin
                    check($sformatf("cnt_ch%0d", ch), {5'd0, cnt_of(ch)}, {5'd0, mon_c.cnt});
                end
                check("cnt_range", {9'd0, ($signed(cnt0) >= -10) && ($signed(cnt0) <= 10)}, 10'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    int blank_len[4] = '{16, 1, 2, 5};
    logic [7:0] extremes[6] = '{8'hFF, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'h01};

    initial begin
        reset_n   = 1'b1;
        de        = 1'b0;
        data      = 8'h00;
        ctrl      = 2'b00;
        in_reset  = 1'b1;
        m_cnt     = 0;
        m_prev_de = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_init");
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("reset_init_hold");
        release_reset();
        repeat (4) drive(1'b0, 8'($urandom_range(0, 255)), 2'b00);

        for (int k = 0; k < 4; k++) drive(1'b0, 8'($urandom_range(0, 255)), 2'(k));
        repeat (3) drive(1'b0, 8'($urandom_range(0, 255)), 2'b00);

        repeat (3) drive(1'b1, 8'h00, 2'b00);
        repeat (4) drive(1'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));

        foreach (extremes[k]) drive(1'b1, extremes[k], 2'b00);
        repeat (3) drive(1'b0, 8'h00, 2'b01);

        for (int line = 0; line < 4; line++) begin
            for (int p = 0; p < 640; p++) drive(1'b1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
            for (int b = 0; b < blank_len[line]; b++)
                drive(1'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end

        repeat (50) drive(1'b1, 8'($urandom_range(0, 255)), 2'b00);
        assert_reset();
        repeat (2) @(posedge clk);
        release_reset();
        repeat (5) drive(1'b0, 8'($urandom_range(0, 255)), 2'b00);
        repeat (20) drive(1'b1, 8'($urandom_range(0, 255)), 2'b00);
        repeat (3) drive(1'b0, 8'($urandom_range(0, 255)), 2'b10);

        for (int k = 0; k < 20 && (exp_q.size() > 0 || cnt_q.size() > 0); k++) @(posedge clk);
        #3;
        check("drain_sym_queue", 10'(exp_q.size()), 10'd0);
        check("drain_cnt_queue", 10'(cnt_q.size()), 10'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
